// File: rtl/dpwm_pkg.sv
// Shared types and defaults for the DPWM clock-divider controller.
// Optional observation ports are enabled by defining DPWM_DIV_OBS_EN.
package dpwm_pkg;

    localparam int DPWM_CNT_W   = 23;
    localparam int DPWM_DEF_DIV = 6250000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dpwm_state_t;

endpackage

// File: rtl/dpwm_div_core.sv
// Divider datapath: half-period counter, terminal-count compare and freq_out toggle.
// With DPWM_DIV_OBS_EN defined, the live count is exported on o_cnt.
module dpwm_div_core
    import dpwm_pkg::*;
#(
    parameter int CNT_W = DPWM_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_active,
`ifdef DPWM_DIV_OBS_EN
    output logic [CNT_W-1:0] o_cnt,
`endif
    output logic             o_tc,
    output logic             o_freq_out,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_freq_out;
    logic             r_tick;

    // Ratio updates only land on a TC edge, when cnt restarts at 0, so cnt never passes active.
    assign o_tc = i_run && (r_cnt == i_active);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_freq_out <= 1'b0;
            r_tick     <= 1'b0;
        end else if (!i_run) begin
            r_cnt      <= '0;
            r_freq_out <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_cnt  <= o_tc ? '0 : r_cnt + 1'b1;
            r_tick <= o_tc;
            if (o_tc) begin
                r_freq_out <= ~r_freq_out;
            end
        end
    end

    assign o_freq_out = r_freq_out;
    assign o_tick     = r_tick;
`ifdef DPWM_DIV_OBS_EN
    assign o_cnt      = r_cnt;
`endif

endmodule

// File: rtl/dpwm_div_ctrl.sv
// Run-time controller for the DPWM divider: start/stop FSM, glitch-free ratio updates.
// Define DPWM_DIV_OBS_EN to add the cnt_obs and tc_count observation outputs.
module dpwm_div_ctrl
    import dpwm_pkg::*;
#(
    parameter int CNT_W   = DPWM_CNT_W,
    parameter int DEF_DIV = DPWM_DEF_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             tick,
    output logic             freq_out,
    output logic             busy,
`ifdef DPWM_DIV_OBS_EN
    output logic [CNT_W-1:0] cnt_obs,
    output logic [15:0]      tc_count,
`endif
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] DEF_RATIO = CNT_W'(DEF_DIV);

    dpwm_state_t      r_state;
    dpwm_state_t      w_state_next;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_cfg_err;
    logic             w_run;
    logic             w_tc;
    logic             w_xfer;
    logic             w_xfer_ok;
    logic             w_boundary;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (en)  w_state_next = RUN;
            RUN:     if (!en) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_run      = (r_state == RUN) && en;
    assign w_xfer     = cfg_valid && !r_pending;
    assign w_xfer_ok  = w_xfer && (cfg_div != '0);
    // Points where active may change without shortening a half-period: idle, TC, or stopping.
    assign w_boundary = (r_state == IDLE) || !en || w_tc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active  <= DEF_RATIO;
            r_shadow  <= DEF_RATIO;
            r_pending <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_xfer && (cfg_div == '0);
            if (w_boundary) begin
                if (r_pending) begin
                    r_active  <= r_shadow;
                    r_pending <= 1'b0;
                end else if (w_xfer_ok) begin
                    r_active <= cfg_div;
                end
            end else if (w_xfer_ok) begin
                r_shadow  <= cfg_div;
                r_pending <= 1'b1;
            end
        end
    end

    dpwm_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .i_run      (w_run),
        .i_active   (r_active),
`ifdef DPWM_DIV_OBS_EN
        .o_cnt      (cnt_obs),
`endif
        .o_tc       (w_tc),
        .o_freq_out (freq_out),
        .o_tick     (tick)
    );

`ifdef DPWM_DIV_OBS_EN
    logic [15:0] r_tc_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tc_count <= '0;
        end else if (w_tc) begin
            r_tc_count <= r_tc_count + 16'd1;
        end
    end

    assign tc_count = r_tc_count;
`endif

    assign cfg_ready = !r_pending;
    assign busy      = (r_state == RUN);
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_dpwm_div_ctrl.sv
// Directed bench for dpwm_div_ctrl (DEF_DIV=3); half-period lengths are checked via a scoreboard queue.
module tb_dpwm_div_ctrl;

    localparam int CW = 23;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [CW-1:0] cfg_div = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          tick;
    logic          freq_out;
    logic          busy;
    logic          cfg_err;
`ifdef DPWM_DIV_OBS_EN
    logic [CW-1:0] cnt_obs;
    logic [15:0]   tc_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    bit mon_en = 1'b0;

    dpwm_div_ctrl #(
        .CNT_W   (CW),
        .DEF_DIV (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .tick      (tick),
        .freq_out  (freq_out),
        .busy      (busy),
`ifdef DPWM_DIV_OBS_EN
        .cnt_obs   (cnt_obs),
        .tc_count  (tc_count),
`endif
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    // Monitor: tick must coincide with each freq_out toggle; toggle spacing is popped from the queue.
    logic prev_fo = 1'b0;
    bit   have_last = 1'b0;
    int   cyc = 0;
    int   last_cyc = 0;
    always @(posedge clk) begin
        logic toggled;
        int   e;
        #1;
        cyc++;
        toggled = (freq_out !== prev_fo);
        if (mon_en && !reset) begin
            n_vec++;
            assert (tick === toggled) else begin
                n_err++;
                $error("FAIL tick_vs_toggle @cyc %0d: observed tick=%b expected %b", cyc, tick, toggled);
            end
            if (toggled) begin
                if (have_last && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    assert ((cyc - last_cyc) === e) else begin
                        n_err++;
                        $error("FAIL half_period @cyc %0d: observed %0d clks expected %0d", cyc, cyc - last_cyc, e);
                    end
                end
                have_last = 1'b1;
                last_cyc  = cyc;
            end
        end else begin
            have_last = 1'b0;
        end
        prev_fo = freq_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tick !== 1'b1 && k < 40);
        n_vec++;
        assert (tick === 1'b1) else begin
            n_err++;
            $error("FAIL %s: observed tick=%b after %0d clks expected 1", tag, tick, k);
        end
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL %s: observed %0d half-periods outstanding expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic send(input logic [CW-1:0] div);
        cfg_div   = div;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        $display("cfg transfer: cfg_div=%0d at cyc %0d", div, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values while reset is held, then after release.
        repeat (2) @(negedge clk);
        check("rst_ready", cfg_ready, 1);
        check("rst_tick", tick, 0);
        check("rst_freq", freq_out, 0);
        check("rst_busy", busy, 0);
        check("rst_err", cfg_err, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_freq", freq_out, 0);
        check("idle_busy", busy, 0);

        // 1. Default ratio 3: 4-clk half-periods.
        en = 1'b1;
        mon_en = 1'b1;
        exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(4);
        @(negedge clk);
        @(negedge clk);
        check("s1_busy", busy, 1);
        wait_drain("s1_drain");

        // 2. Mid-period ratio 1: current half stays 4, then 2.
        wait_tick("s2_sync");
        exp_q.push_back(4); exp_q.push_back(2); exp_q.push_back(2);
        send(1);
        check("s2_ready_low", cfg_ready, 0);
        wait_tick("s2_tc");
        check("s2_ready_back", cfg_ready, 1);
        wait_drain("s2_drain");

        // 3. Ratio 5 presented on the TC edge: bypass straight to active.
        wait_tick("s3_sync");
        @(negedge clk);
        exp_q.push_back(2); exp_q.push_back(6); exp_q.push_back(6);
        send(5);
        check("s3_ready", cfg_ready, 1);
        check("s3_tc_tick", tick, 1);
        wait_drain("s3_drain");

        // 4. Zero ratio rejected with one-cycle cfg_err.
        exp_q.push_back(6); exp_q.push_back(6);
        send(0);
        check("s4_err", cfg_err, 1);
        check("s4_ready", cfg_ready, 1);
        @(negedge clk);
        check("s4_err_clr", cfg_err, 0);
        wait_drain("s4_drain");

        // 5. Pending ratio 2 then stop: applied on the way to IDLE.
        send(2);
        check("s5_ready_low", cfg_ready, 0);
        mon_en = 1'b0;
        en = 1'b0;
        @(negedge clk);
        check("s5_busy", busy, 0);
        check("s5_freq", freq_out, 0);
        check("s5_ready", cfg_ready, 1);
        check("s5_tick", tick, 0);
        repeat (3) @(negedge clk);
        check("s5_freq_hold", freq_out, 0);
        en = 1'b1;
        mon_en = 1'b1;
        exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(3);
        wait_drain("s5_drain");

        // 6. Async reset between edges with freq_out high and a ratio pending.
        for (int i = 0; i < 4; i++) begin
            wait_tick("s6_sync");
            if (freq_out) break;
        end
        @(negedge clk);
        send(7);
        check("s6_ready_low", cfg_ready, 0);
        check("s6_freq_pre", freq_out, 1);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("s6_async_ready", cfg_ready, 1);
        check("s6_async_busy", busy, 0);
        check("s6_async_freq", freq_out, 0);
        check("s6_async_tick", tick, 0);
        check("s6_async_err", cfg_err, 0);
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(4);
        wait_drain("s6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
